regfile_wb_port: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file with its write-back port.
- Consumes the destination register number chosen by the datapath's register-destination select (rt or rd), decodes it to a one-hot write enable and commits write-back data on the clock edge.
- Provides two combinational read ports (rs, rt).
- Keeps a pending-write scoreboard so the issue logic can detect RAW hazards on registers still awaiting write-back.

---
 rtl/regfile_wb_port.sv | 93 +++++++++
 tb/tb_regfile_wb_port.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_port.sv
// 32 x 32 MIPS register file with write-back port, two combinational read ports
// and a pending-write scoreboard. Define REGFILE_WB_BYPASS_EN for write-through forwarding.
module regfile_wb_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   pending_cnt
);
    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]  sb_reg;
    logic [NREGS-1:0]  sb_next;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   cnt_next;
    logic [NREGS-1:0]  wr_dec;
    logic [NREGS-1:0]  rsv_dec;

    // Register 0 never decodes, so it can be neither written nor reserved.
    assign wr_dec[0]  = 1'b0;
    assign rsv_dec[0] = 1'b0;
    assign sb_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_dec
            assign wr_dec[gi]  = wr_en  && (wr_addr  == ADDR_W'(gi));
            assign rsv_dec[gi] = rsv_en && (rsv_addr == ADDR_W'(gi));
            // A same-edge reservation outranks the write-back clear.
            assign sb_next[gi] = rsv_dec[gi] | (sb_reg[gi] & ~wr_dec[gi]);
        end
    endgenerate

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, sb_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
            sb_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_dec[i]) begin
                    regs_reg[i] <= wr_data;
                end
            end
            sb_reg  <= sb_next;
            cnt_reg <= cnt_next;
        end
    end

    assign pending_cnt = cnt_reg;

`ifdef REGFILE_WB_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    assign fwd_a = wr_en && (wr_addr != '0) && (wr_addr == rd_addr_a);
    assign fwd_b = wr_en && (wr_addr != '0) && (wr_addr == rd_addr_b);

    assign rd_data_a = fwd_a ? wr_data : regs_reg[rd_addr_a];
    assign rd_data_b = fwd_b ? wr_data : regs_reg[rd_addr_b];

    // A forwarded register is only still busy if a newer instruction reserves it now.
    assign busy_a = fwd_a ? (rsv_en && (rsv_addr == rd_addr_a)) : sb_reg[rd_addr_a];
    assign busy_b = fwd_b ? (rsv_en && (rsv_addr == rd_addr_b)) : sb_reg[rd_addr_b];
`else
    assign rd_data_a = regs_reg[rd_addr_a];
    assign rd_data_b = regs_reg[rd_addr_b];
    assign busy_a    = sb_reg[rd_addr_a];
    assign busy_b    = sb_reg[rd_addr_b];
`endif

endmodule

// File: tb/tb_regfile_wb_port.sv
// Directed bench for regfile_wb_port: reset, write decode, r0, scoreboard, bypass timing.
module tb_regfile_wb_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        busy_a;
    logic        busy_b;
    logic [5:0]  pending_cnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    regfile_wb_port #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change 1ns after it, outputs are sampled 1ns later still.
    task automatic tick();
        $display("cycle %0d: rst_n=%b wr=%b r%0d<=%h rsv=%b r%0d", cycle, rst_n, wr_en,
                 wr_addr, wr_data, rsv_en, rsv_addr);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
        #1;
        check("reset_rd_a", rd_data_a, 32'h0);
        check("reset_cnt", {26'b0, pending_cnt}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Reset mid-run
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle(); rd_addr_a = 5'd5; rd_addr_b = 5'd7;
        #1;
        check("pre_rst_r5", rd_data_a, 32'hDEADBEEF);
        check("pre_rst_cnt", {26'b0, pending_cnt}, 32'd1);
        check("pre_rst_busy_b", {31'b0, busy_b}, 32'd1);
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0BADF00D;
        #1;
        check("async_rst_r5", rd_data_a, 32'h0);
        check("async_rst_cnt", {26'b0, pending_cnt}, 32'd0);
        tick();
        idle(); rst_n = 1'b1; rd_addr_a = 5'd7;
        #1;
        check("post_rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("post_rst_r5", rd_data_b == 32'h0 ? 32'h0 : rd_data_b, 32'h0);
        rd_addr_a = 5'd5;
        #1;
        check("post_rst_r5_a", rd_data_a, 32'h0);

        // Write decode
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h11111111;
        tick();
        wr_addr = 5'd31; wr_data = 32'hFFFF0000;
        tick();
        idle(); rd_addr_a = 5'd1; rd_addr_b = 5'd31;
        #1;
        check("wr_r1", rd_data_a, 32'h11111111);
        check("wr_r31", rd_data_b, 32'hFFFF0000);
        rd_addr_a = 5'd2;
        #1;
        check("r2_untouched", rd_data_a, 32'h0);

        // Register 0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle(); rd_addr_a = 5'd0;
        #1;
        check("r0_data", rd_data_a, 32'h0);
        check("r0_busy", {31'b0, busy_a}, 32'd0);
        check("r0_cnt", {26'b0, pending_cnt}, 32'd0);

        // Scoreboard
        rsv_en = 1'b1; rsv_addr = 5'd8;
        tick();
        rsv_addr = 5'd9;
        tick();
        idle(); rd_addr_a = 5'd8; rd_addr_b = 5'd9;
        #1;
        check("sb_cnt2", {26'b0, pending_cnt}, 32'd2);
        check("sb_busy_r8", {31'b0, busy_a}, 32'd1);
        check("sb_busy_r9", {31'b0, busy_b}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hA5A5A5A5;
        tick();
        idle();
        #1;
        check("sb_cnt1", {26'b0, pending_cnt}, 32'd1);
        check("sb_clr_r8", {31'b0, busy_a}, 32'd0);
        check("sb_data_r8", rd_data_a, 32'hA5A5A5A5);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        #1;
        check("waw_cnt", {26'b0, pending_cnt}, 32'd1);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99999999;
        tick();
        idle();
        #1;
        check("same_edge_busy", {31'b0, busy_b}, 32'd1);
        check("same_edge_cnt", {26'b0, pending_cnt}, 32'd1);
        check("same_edge_data", rd_data_b, 32'h99999999);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33333333;
        tick();
        idle(); rd_addr_a = 5'd3;
        #1;
        check("clear_bit_write_cnt", {26'b0, pending_cnt}, 32'd1);
        check("clear_bit_write_data", rd_data_a, 32'h33333333);
        rsv_en = 1'b1; rsv_addr = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h09090909;
        tick();
        idle(); rd_addr_a = 5'd10;
        #1;
        check("plus_minus_cnt", {26'b0, pending_cnt}, 32'd1);
        check("plus_minus_r10", {31'b0, busy_a}, 32'd1);
        check("plus_minus_r9", {31'b0, busy_b}, 32'd0);

        // Bypass timing
        rd_addr_a = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFEF00D;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        check("bypass_same_cycle", rd_data_a, 32'hCAFEF00D);
`else
        check("bypass_same_cycle", rd_data_a, 32'h0);
`endif
        check("bypass_busy", {31'b0, busy_a}, 32'd0);
        tick();
        idle();
        #1;
        check("bypass_next_cycle", rd_data_a, 32'hCAFEF00D);

        // Fill the scoreboard, then drain it
        for (int i = 1; i < 32; i++) begin
            rsv_en = 1'b1; rsv_addr = 5'(i);
            tick();
        end
        idle(); rd_addr_a = 5'd31; rd_addr_b = 5'd0;
        #1;
        check("full_cnt", {26'b0, pending_cnt}, 32'd31);
        check("full_busy_r31", {31'b0, busy_a}, 32'd1);
        check("full_busy_r0", {31'b0, busy_b}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        idle();
        #1;
        check("drain_cnt", {26'b0, pending_cnt}, 32'd0);
        check("drain_r31", rd_data_a, 32'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
